// File: rtl/radar_sweep_ctrl.sv
// Pan-servo sweep sequencer: steps the servo through left/center/right in ping-pong
// order, settles, runs one ranger handshake per point and publishes (position, distance).
module radar_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES  = 30_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 6_000_000,
    parameter int unsigned DIST_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              single,
    output logic [1:0]        servo_pos,
    output logic              meas_req,
    input  logic              meas_done,
    input  logic [DIST_W-1:0] meas_dist,
    output logic              result_valid,
    output logic [1:0]        result_pos,
    output logic [DIST_W-1:0] result_dist,
    output logic              result_timeout,
    output logic              busy
);

    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] POS_LEFT   = 2'd1;
    localparam logic [1:0] POS_CENTER = 2'd2;
    localparam logic [1:0] POS_RIGHT  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE,
        S_SETTLE,
        S_MEASURE,
        S_REPORT
    } state_t;

    state_t            state, state_d;
    logic              dir_down, dir_down_d;
    logic              single_q, single_d;
    logic [SET_W-1:0]  settle_cnt, settle_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_d;
    logic [1:0]        servo_pos_d;
    logic              meas_req_d;
    logic              result_valid_d;
    logic [1:0]        result_pos_d;
    logic [DIST_W-1:0] result_dist_d;
    logic              result_timeout_d;
    logic              busy_d;
    logic [1:0]        next_pos;
    logic              next_dir_down;

    // Ping-pong successor of the current position: 1,2,3,2,1,2,...
    always_comb begin
        next_pos      = servo_pos;
        next_dir_down = dir_down;
        if (!dir_down) begin
            if (servo_pos == POS_RIGHT) begin
                next_pos      = POS_CENTER;
                next_dir_down = 1'b1;
            end else begin
                next_pos = servo_pos + 2'd1;
            end
        end else begin
            if (servo_pos == POS_LEFT) begin
                next_pos      = POS_CENTER;
                next_dir_down = 1'b0;
            end else begin
                next_pos = servo_pos - 2'd1;
            end
        end
    end

    // Next-state and registered-output values
    always_comb begin
        state_d          = state;
        dir_down_d       = dir_down;
        single_d         = single_q;
        settle_cnt_d     = settle_cnt;
        tmo_cnt_d        = tmo_cnt;
        servo_pos_d      = servo_pos;
        meas_req_d       = 1'b0;
        result_valid_d   = 1'b0;
        result_pos_d     = result_pos;
        result_dist_d    = result_dist;
        result_timeout_d = result_timeout;

        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_d      = S_MOVE;
                    servo_pos_d  = POS_LEFT;
                    dir_down_d   = 1'b0;
                    single_d     = single;
                    settle_cnt_d = SET_LOAD;
                end
            end
            // Counter was loaded when servo_pos changed, so the request rises
            // exactly SETTLE_CYCLES after the position update.
            S_MOVE, S_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_d    = S_MEASURE;
                    meas_req_d = 1'b1;
                    tmo_cnt_d  = '0;
                end else begin
                    state_d      = S_SETTLE;
                    settle_cnt_d = settle_cnt - SET_W'(1);
                end
            end
            S_MEASURE: begin
                if (meas_done) begin
                    state_d          = S_REPORT;
                    result_valid_d   = 1'b1;
                    result_pos_d     = servo_pos;
                    result_dist_d    = meas_dist;
                    result_timeout_d = 1'b0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_d          = S_REPORT;
                    result_valid_d   = 1'b1;
                    result_pos_d     = servo_pos;
                    result_dist_d    = '1;
                    result_timeout_d = 1'b1;
                end else begin
                    meas_req_d = 1'b1;
                    tmo_cnt_d  = tmo_cnt + TMO_W'(1);
                end
            end
            S_REPORT: begin
                if (!enable || (single_q && (servo_pos == POS_RIGHT))) begin
                    state_d = S_IDLE;
                end else begin
                    state_d      = S_MOVE;
                    servo_pos_d  = next_pos;
                    dir_down_d   = next_dir_down;
                    settle_cnt_d = SET_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            dir_down       <= 1'b0;
            single_q       <= 1'b0;
            settle_cnt     <= '0;
            tmo_cnt        <= '0;
            servo_pos      <= POS_CENTER;
            meas_req       <= 1'b0;
            result_valid   <= 1'b0;
            result_pos     <= 2'd0;
            result_dist    <= '0;
            result_timeout <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_d;
            dir_down       <= dir_down_d;
            single_q       <= single_d;
            settle_cnt     <= settle_cnt_d;
            tmo_cnt        <= tmo_cnt_d;
            servo_pos      <= servo_pos_d;
            meas_req       <= meas_req_d;
            result_valid   <= result_valid_d;
            result_pos     <= result_pos_d;
            result_dist    <= result_dist_d;
            result_timeout <= result_timeout_d;
            busy           <= busy_d;
        end
    end

endmodule

// File: tb/tb_radar_sweep_ctrl.sv
// Bench for radar_sweep_ctrl: event-level sweep model checked every cycle on the
// falling edge, plus directed scenarios with literal expectations.
module tb_radar_sweep_ctrl;

    localparam int SETTLE = 10;
    localparam int TMO    = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        single;
    logic [1:0]  servo_pos;
    logic        meas_req;
    logic        meas_done;
    logic [15:0] meas_dist;
    logic        result_valid;
    logic [1:0]  result_pos;
    logic [15:0] result_dist;
    logic        result_timeout;
    logic        busy;

    // ranger behaviour knobs
    logic        rng_en;
    int          resp_delay;
    logic        use_fixed;
    logic [15:0] fixed_dist;

    int n_pass  = 0;
    int n_total = 0;

    // published points, as seen on the result bus
    logic [1:0]  lg_pos[$];
    logic [15:0] lg_dist[$];
    logic        lg_to[$];

    radar_sweep_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO),
        .DIST_W        (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .single        (single),
        .servo_pos     (servo_pos),
        .meas_req      (meas_req),
        .meas_done     (meas_done),
        .meas_dist     (meas_dist),
        .result_valid  (result_valid),
        .result_pos    (result_pos),
        .result_dist   (result_dist),
        .result_timeout(result_timeout),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // k-th point of a sweep started from IDLE
    function automatic logic [1:0] pp(input int k);
        case (k % 4)
            0:       return 2'd1;
            1:       return 2'd2;
            2:       return 2'd3;
            default: return 2'd2;
        endcase
    endfunction

    // Ranger: answers resp_delay cycles into a request (0 = never)
    task automatic ranger();
        int hc = 0;
        forever begin
            tick();
            if (rng_en) begin
                hc = meas_req ? hc + 1 : 0;
                if (meas_req && resp_delay != 0 && hc == resp_delay) begin
                    meas_done = 1'b1;
                    meas_dist = use_fixed ? fixed_dist : 16'(100 * int'(servo_pos));
                end else begin
                    meas_done = 1'b0;
                    meas_dist = 16'($urandom);
                end
            end else begin
                hc = 0;
            end
        end
    endtask

    // Sweep model: tracks expected point order, settle spacing, request length and publishes
    task automatic monitor();
        int          cyc = 0;
        int          last_chg = 0;
        int          hcnt = 0;
        int          seq_idx = 0;
        bit          rst_p = 1'b1;
        bit          m_idle = 1'b1;
        bit          exp_rv = 1'b0;
        bit          exp_move = 1'b0;
        bit          exp_idle = 1'b0;
        bit          single_l = 1'b0;
        bit          rv_n, mv_n, id_n;
        bit          e_to = 1'b0;
        bit          prev_req = 1'b0;
        logic [1:0]  e_pos = 2'd0;
        logic [1:0]  mv_tgt = 2'd0;
        logic [1:0]  prev_pos = 2'd2;
        logic [15:0] e_dist = 16'd0;
        forever begin
            @(negedge clk);
            cyc++;
            rv_n = 1'b0;
            mv_n = 1'b0;
            id_n = 1'b0;
            if (rst_p) begin
                chk("reset_servo_pos", int'(servo_pos), 2);
                chk("reset_meas_req", int'(meas_req), 0);
                chk("reset_result_valid", int'(result_valid), 0);
                chk("reset_result_pos", int'(result_pos), 0);
                chk("reset_result_dist", int'(result_dist), 0);
                chk("reset_result_timeout", int'(result_timeout), 0);
                chk("reset_busy", int'(busy), 0);
                m_idle = 1'b1;
                hcnt   = 0;
            end else begin
                if (exp_idle) m_idle = 1'b1;
                chk("busy", int'(busy), int'(!m_idle));
                chk("result_valid", int'(result_valid), int'(exp_rv));
                if (exp_rv) begin
                    chk("result_pos", int'(result_pos), int'(e_pos));
                    chk("result_dist", int'(result_dist), int'(e_dist));
                    chk("result_timeout", int'(result_timeout), int'(e_to));
                    chk("req_drop", int'(meas_req), 0);
                    lg_pos.push_back(result_pos);
                    lg_dist.push_back(result_dist);
                    lg_to.push_back(result_timeout);
                    seq_idx++;
                    if (!enable || (single_l && e_pos == 2'd3)) begin
                        id_n = 1'b1;
                    end else begin
                        mv_n   = 1'b1;
                        mv_tgt = pp(seq_idx);
                    end
                end else if (prev_req) begin
                    chk("req_hold", int'(meas_req), 1);
                end
                if (exp_move) begin
                    chk("move_pos", int'(servo_pos), int'(mv_tgt));
                    last_chg = cyc;
                end else begin
                    chk("pos_stable", int'(servo_pos), int'(prev_pos));
                end
                if (meas_req && !prev_req) begin
                    chk("settle_time", cyc - last_chg, SETTLE);
                    chk("req_pos", int'(servo_pos), int'(pp(seq_idx)));
                    hcnt = 1;
                end else if (meas_req) begin
                    hcnt++;
                end
                if (meas_req && (meas_done || hcnt == TMO)) begin
                    rv_n   = 1'b1;
                    e_pos  = servo_pos;
                    e_dist = meas_done ? meas_dist : 16'hFFFF;
                    e_to   = !meas_done;
                end
            end
            if (m_idle && enable && !rst) begin
                m_idle   = 1'b0;
                mv_n     = 1'b1;
                mv_tgt   = 2'd1;
                seq_idx  = 0;
                single_l = single;
            end
            exp_rv   = rv_n;
            exp_move = mv_n;
            exp_idle = id_n;
            prev_pos = servo_pos;
            prev_req = meas_req;
            rst_p    = rst;
        end
    endtask

    task automatic wait_pubs(input int n, input int budget);
        int k = 0;
        while (lg_pos.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("wait_pubs", lg_pos.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        chk("wait_idle", int'(busy), 0);
    endtask

    task automatic clear_log();
        lg_pos.delete();
        lg_dist.delete();
        lg_to.delete();
    endtask

    initial begin
        logic [1:0] sweep_exp[7];
        int k;
        int n;
        int n0;
        sweep_exp = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd2, 2'd3};
        rst        = 1'b1;
        enable     = 1'b0;
        single     = 1'b0;
        meas_done  = 1'b0;
        meas_dist  = 16'd0;
        rng_en     = 1'b1;
        resp_delay = 5;
        use_fixed  = 1'b0;
        fixed_dist = 16'd0;
        fork
            monitor();
            ranger();
        join_none

        repeat (3) tick();
        chk("lit_rst_servo_pos", int'(servo_pos), 2);
        chk("lit_rst_busy", int'(busy), 0);
        rst = 1'b0;
        tick();

        // single pass 1->2->3
        single = 1'b1;
        enable = 1'b1;
        wait_pubs(3, 200);
        chk("single_busy_after", int'(busy), 0);
        enable = 1'b0;
        chk("single_p0_pos", int'(lg_pos[0]), 1);
        chk("single_p0_dist", int'(lg_dist[0]), 100);
        chk("single_p1_pos", int'(lg_pos[1]), 2);
        chk("single_p1_dist", int'(lg_dist[1]), 200);
        chk("single_p2_pos", int'(lg_pos[2]), 3);
        chk("single_p2_dist", int'(lg_dist[2]), 300);
        chk("single_p2_to", int'(lg_to[2]), 0);
        wait_idle(10);

        // continuous ping-pong sweep
        clear_log();
        single = 1'b0;
        enable = 1'b1;
        wait_pubs(7, 300);
        enable = 1'b0;
        wait_idle(60);
        for (int i = 0; i < 7; i++) chk("sweep_pos", int'(lg_pos[i]), int'(sweep_exp[i]));

        // ranger never answers
        clear_log();
        resp_delay = 0;
        enable     = 1'b1;
        k = 0;
        while (!meas_req && k < 40) begin
            tick();
            k++;
        end
        chk("wait_req", int'(meas_req), 1);
        n = 0;
        while (meas_req && n < 100) begin
            n++;
            tick();
        end
        chk("timeout_req_width", n, 20);
        wait_pubs(2, 100);
        enable = 1'b0;
        wait_idle(100);
        chk("tmo_p0_pos", int'(lg_pos[0]), 1);
        chk("tmo_p0_dist", int'(lg_dist[0]), 16'hFFFF);
        chk("tmo_p0_to", int'(lg_to[0]), 1);
        chk("tmo_p1_pos", int'(lg_pos[1]), 2);
        chk("tmo_p1_to", int'(lg_to[1]), 1);

        // done in the same cycle as timeout expiry
        clear_log();
        resp_delay = 20;
        use_fixed  = 1'b1;
        fixed_dist = 16'd42;
        enable     = 1'b1;
        tick();
        enable = 1'b0;
        wait_pubs(1, 60);
        wait_idle(10);
        chk("tie_count", lg_pos.size(), 1);
        chk("tie_pos", int'(lg_pos[0]), 1);
        chk("tie_dist", int'(lg_dist[0]), 42);
        chk("tie_to", int'(lg_to[0]), 0);

        // enable dropped while settling at position 2, then re-enable
        clear_log();
        resp_delay = 5;
        use_fixed  = 1'b0;
        enable     = 1'b1;
        k = 0;
        while (servo_pos != 2'd2 && k < 60) begin
            tick();
            k++;
        end
        chk("reach_pos2", int'(servo_pos), 2);
        repeat (3) tick();
        enable = 1'b0;
        wait_idle(60);
        chk("drop_count", lg_pos.size(), 2);
        chk("drop_p1_pos", int'(lg_pos[1]), 2);
        chk("drop_p1_dist", int'(lg_dist[1]), 200);
        enable = 1'b1;
        tick();
        chk("restart_pos", int'(servo_pos), 1);
        enable = 1'b0;
        wait_idle(60);

        // reset during MEASURE, then a stray done while idle
        enable = 1'b1;
        k = 0;
        while (!meas_req && k < 40) begin
            tick();
            k++;
        end
        chk("wait_req_rst", int'(meas_req), 1);
        repeat (2) tick();
        rst    = 1'b1;
        enable = 1'b0;
        tick();
        chk("mid_rst_req", int'(meas_req), 0);
        chk("mid_rst_servo_pos", int'(servo_pos), 2);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_valid", int'(result_valid), 0);
        rst = 1'b0;
        n0 = lg_pos.size();
        rng_en = 1'b0;
        tick();
        meas_done = 1'b1;
        meas_dist = 16'd77;
        tick();
        meas_done = 1'b0;
        repeat (3) begin
            tick();
            chk("stray_valid", int'(result_valid), 0);
        end
        chk("stray_busy", int'(busy), 0);
        chk("stray_nopub", lg_pos.size(), n0);

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
